// File: rtl/pkt_len_meas.sv
// Packet length meter: counts bytes per stream packet, reports length and flow
// one cycle after eop, and flags/counts framing errors.
module pkt_len_meas #(
  parameter int A_WIDTH    = 3,
  parameter int DATA_BYTES = 8,
  parameter int EMPTY_W    = 3
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               st_valid_i,
  input  logic               st_sop_i,
  input  logic               st_eop_i,
  input  logic [EMPTY_W-1:0] st_empty_i,
  input  logic [A_WIDTH-1:0] st_flow_num_i,
  output logic [A_WIDTH-1:0] rx_flow_num_o,
  output logic [15:0]        pkt_size_o,
  output logic               pkt_size_ena_o,
  output logic               err_o,
  output logic [15:0]        err_cnt_o
);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  localparam logic [16:0] FULL_BEAT = 17'(DATA_BYTES);

  state_t             state;
  logic [16:0]        acc;
  logic [A_WIDTH-1:0] flow_q;
  logic [1:0]         rst_sync;
  logic               rst_n;

  // NOTE: assertion is asynchronous, release is re-timed to clk_i so no flop
  // leaves reset on a different edge than its neighbours.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  function automatic logic [15:0] sat16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

  // acc never exceeds 16'hFFFF, so these sums cannot wrap 17 bits.
  logic [16:0] eop_bytes;
  logic [16:0] mid_sum;
  logic [16:0] eop_sum;
  logic        err_evt;

  always_comb begin
    eop_bytes = FULL_BEAT - 17'(st_empty_i);
    mid_sum   = acc + FULL_BEAT;
    eop_sum   = acc + eop_bytes;
    err_evt   = st_valid_i &&
                (((state == IDLE) && !st_sop_i) || ((state == IN_PKT) && st_sop_i));
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc            <= '0;
      flow_q         <= '0;
      rx_flow_num_o  <= '0;
      pkt_size_o     <= '0;
      pkt_size_ena_o <= 1'b0;
      err_o          <= 1'b0;
      err_cnt_o      <= '0;
    end else begin
      pkt_size_ena_o <= 1'b0;
      err_o          <= err_evt;
      if (err_evt && (err_cnt_o != 16'hFFFF)) err_cnt_o <= err_cnt_o + 16'd1;

      if (st_valid_i) begin
        if (st_sop_i) begin
          // A sop in IN_PKT aborts the open packet; either way the beat starts anew.
          if (st_eop_i) begin
            pkt_size_o     <= sat16(eop_bytes);
            rx_flow_num_o  <= st_flow_num_i;
            pkt_size_ena_o <= 1'b1;
            acc            <= '0;
            state          <= IDLE;
          end else begin
            acc    <= FULL_BEAT;
            flow_q <= st_flow_num_i;
            state  <= IN_PKT;
          end
        end else if (state == IN_PKT) begin
          if (st_eop_i) begin
            pkt_size_o     <= sat16(eop_sum);
            rx_flow_num_o  <= flow_q;
            pkt_size_ena_o <= 1'b1;
            acc            <= '0;
            state          <= IDLE;
          end else begin
            acc <= {1'b0, sat16(mid_sum)};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pkt_len_meas.sv
// Self-checking bench for pkt_len_meas: directed scenarios plus randomized
// traffic compared against a packet-level reference model.
module tb_pkt_len_meas;
  localparam int A_WIDTH    = 3;
  localparam int DATA_BYTES = 8;
  localparam int EMPTY_W    = 3;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic               st_valid_i, st_sop_i, st_eop_i;
  logic [EMPTY_W-1:0] st_empty_i;
  logic [A_WIDTH-1:0] st_flow_num_i;
  logic [A_WIDTH-1:0] rx_flow_num_o;
  logic [15:0]        pkt_size_o;
  logic               pkt_size_ena_o;
  logic               err_o;
  logic [15:0]        err_cnt_o;

  pkt_len_meas #(.A_WIDTH(A_WIDTH), .DATA_BYTES(DATA_BYTES), .EMPTY_W(EMPTY_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .st_valid_i(st_valid_i), .st_sop_i(st_sop_i), .st_eop_i(st_eop_i),
    .st_empty_i(st_empty_i), .st_flow_num_i(st_flow_num_i),
    .rx_flow_num_o(rx_flow_num_o), .pkt_size_o(pkt_size_o),
    .pkt_size_ena_o(pkt_size_ena_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int cyc;
    int flow;
    int size;
  } rep_t;

  rep_t exp_rep[$], act_rep[$];
  int   exp_err[$], act_err[$];
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;

  // Reference model state: a packet is either open or not, length is unbounded.
  bit m_open;
  int m_len, m_flow, m_cnt;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (pkt_size_ena_o) act_rep.push_back('{cyc, int'(rx_flow_num_o), int'(pkt_size_o)});
    if (err_o) act_err.push_back(cyc);
  end

  function automatic int cap(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_err(input int c);
    exp_err.push_back(c);
    if (m_cnt < 65535) m_cnt++;
  endtask

  task automatic beat(input bit v, input bit sop, input bit eop, input int empty, input int flow);
    int c;
    @(negedge clk_i);
    st_valid_i    = v;
    st_sop_i      = sop;
    st_eop_i      = eop;
    st_empty_i    = EMPTY_W'(empty);
    st_flow_num_i = A_WIDTH'(flow);
    c = cyc + 1;
    if (v) begin
      if (sop) begin
        if (m_open) model_err(c);
        if (eop) begin
          exp_rep.push_back('{c, flow, cap(DATA_BYTES - empty)});
          m_open = 0;
        end else begin
          m_open = 1; m_len = DATA_BYTES; m_flow = flow;
        end
      end else if (!m_open) begin
        model_err(c);
      end else if (eop) begin
        exp_rep.push_back('{c, m_flow, cap(m_len + DATA_BYTES - empty)});
        m_open = 0;
      end else begin
        m_len += DATA_BYTES;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7));
  endtask

  task automatic clear_queues();
    exp_rep.delete(); act_rep.delete(); exp_err.delete(); act_err.delete();
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    st_valid_i = 1'b1; st_sop_i = 1'b1; st_eop_i = 1'b1; st_empty_i = '0; st_flow_num_i = 3'd5;
    m_open = 0; m_len = 0; m_flow = 0; m_cnt = 0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({pkt_size_ena_o, err_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_strobes: got ena=%b err=%b required 0 0", pkt_size_ena_o, err_o);
    end
    n_checks++;
    if ({rx_flow_num_o, pkt_size_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got flow=%0d size=%0d cnt=%0d required all 0",
               rx_flow_num_o, pkt_size_o, err_cnt_o);
    end
    st_valid_i = 1'b0;
    rst_n_i    = 1'b1;
    idle(4);
    n_checks++;
    if (act_rep.size() + act_err.size() != 0) begin
      n_fail++;
      $display("FAIL reset_release: got %0d events required 0", act_rep.size() + act_err.size());
    end
    clear_queues();
  endtask

  task automatic test_multi_beat();
    beat(1, 1, 0, 0, 5);
    beat(1, 0, 0, 0, 5);
    beat(1, 0, 0, 0, 5);
    beat(1, 0, 1, 3, 5);
    idle(3);
    n_checks++;
    if (act_rep.size() != 1) begin
      n_fail++; $display("FAIL multi_count: got %0d strobes required 1", act_rep.size());
    end else begin
      n_checks++;
      if (act_rep[0].size != 29) begin
        n_fail++; $display("FAIL multi_size: got %0d required 29", act_rep[0].size);
      end
      n_checks++;
      if (act_rep[0].flow != 5) begin
        n_fail++; $display("FAIL multi_flow: got %0d required 5", act_rep[0].flow);
      end
      n_checks++;
      if (act_rep[0].cyc != exp_rep[0].cyc) begin
        n_fail++; $display("FAIL multi_timing: got cycle %0d required %0d", act_rep[0].cyc, exp_rep[0].cyc);
      end
    end
    n_checks++;
    if (act_err.size() != 0) begin
      n_fail++; $display("FAIL multi_err: got %0d errors required 0", act_err.size());
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    repeat (4) beat(1, 1, 1, 7, 2);
    beat(1, 1, 0, 0, 6);
    beat(1, 0, 1, 0, 6);
    beat(1, 1, 0, 0, 4);
    beat(1, 0, 1, 5, 4);
    idle(3);
    n_checks++;
    if (act_rep.size() != 6) begin
      n_fail++; $display("FAIL b2b_count: got %0d strobes required 6", act_rep.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (act_rep[i].size != 1 || act_rep[i].flow != 2 || act_rep[i].cyc != exp_rep[0].cyc + i) begin
          n_fail++;
          $display("FAIL b2b_single[%0d]: got size=%0d flow=%0d cyc=%0d required 1 2 %0d",
                   i, act_rep[i].size, act_rep[i].flow, act_rep[i].cyc, exp_rep[0].cyc + i);
        end
      end
      n_checks++;
      if (act_rep[4].size != 16 || act_rep[5].size != 11 || act_rep[5].cyc != act_rep[4].cyc + 2) begin
        n_fail++;
        $display("FAIL b2b_two_beat: got sizes %0d %0d cycles %0d %0d required 16 11 two apart",
                 act_rep[4].size, act_rep[5].size, act_rep[4].cyc, act_rep[5].cyc);
      end
    end
    clear_queues();
  endtask

  task automatic test_abort();
    beat(1, 1, 0, 0, 1);
    beat(1, 0, 0, 0, 1);
    beat(1, 1, 1, 0, 3);
    idle(3);
    n_checks++;
    if (act_err.size() != 1 || act_rep.size() != 1) begin
      n_fail++;
      $display("FAIL abort_count: got %0d errors %0d strobes required 1 1", act_err.size(), act_rep.size());
    end else begin
      n_checks++;
      if (act_rep[0].size != 8 || act_rep[0].flow != 3) begin
        n_fail++;
        $display("FAIL abort_report: got size=%0d flow=%0d required 8 3", act_rep[0].size, act_rep[0].flow);
      end
      n_checks++;
      if (act_err[0] != act_rep[0].cyc || act_err[0] != exp_err[0]) begin
        n_fail++;
        $display("FAIL abort_timing: got err cyc %0d strobe cyc %0d required both %0d",
                 act_err[0], act_rep[0].cyc, exp_err[0]);
      end
    end
    n_checks++;
    if (err_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL abort_cnt: got %0d required 1", err_cnt_o);
    end
    clear_queues();
  endtask

  task automatic test_idle_err();
    beat(1, 0, 0, 0, 4);
    beat(1, 0, 1, 2, 4);
    idle(3);
    n_checks++;
    if (act_rep.size() != 0) begin
      n_fail++; $display("FAIL idle_err_strobe: got %0d strobes required 0", act_rep.size());
    end
    n_checks++;
    if (act_err.size() != 2) begin
      n_fail++; $display("FAIL idle_err_count: got %0d errors required 2", act_err.size());
    end else begin
      n_checks++;
      if (act_err[0] != exp_err[0] || act_err[1] != exp_err[1]) begin
        n_fail++;
        $display("FAIL idle_err_timing: got %0d %0d required %0d %0d", act_err[0], act_err[1], exp_err[0], exp_err[1]);
      end
    end
    n_checks++;
    if (err_cnt_o !== 16'd3) begin
      n_fail++; $display("FAIL idle_err_cnt: got %0d required 3", err_cnt_o);
    end
    clear_queues();
  endtask

  task automatic test_saturation();
    beat(1, 1, 0, 0, 6);
    repeat (8200) beat(1, 0, 0, 0, 0);
    beat(1, 0, 1, 0, 0);
    beat(1, 1, 0, 0, 7);
    repeat (8190) beat(1, 0, 0, 0, 0);
    beat(1, 0, 1, 2, 0);
    idle(3);
    n_checks++;
    if (act_rep.size() != 2) begin
      n_fail++; $display("FAIL sat_count: got %0d strobes required 2", act_rep.size());
    end else begin
      n_checks++;
      if (act_rep[0].size != 65535 || act_rep[0].flow != 6) begin
        n_fail++;
        $display("FAIL sat_clip: got size=%0d flow=%0d required 65535 6", act_rep[0].size, act_rep[0].flow);
      end
      n_checks++;
      if (act_rep[1].size != 65534 || act_rep[1].flow != 7) begin
        n_fail++;
        $display("FAIL sat_edge: got size=%0d flow=%0d required 65534 7", act_rep[1].size, act_rep[1].flow);
      end
    end
    clear_queues();
  endtask

  task automatic test_mid_reset();
    beat(1, 1, 0, 0, 4);
    beat(1, 0, 0, 0, 4);
    beat(1, 0, 0, 0, 4);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    st_valid_i = 1'b0;
    m_open = 0; m_cnt = 0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({pkt_size_ena_o, err_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL midrst_hold: got ena=%b err=%b cnt=%0d required 0 0 0", pkt_size_ena_o, err_o, err_cnt_o);
    end
    rst_n_i = 1'b1;
    idle(3);
    beat(1, 1, 0, 0, 1);
    beat(1, 0, 1, 0, 1);
    idle(3);
    n_checks++;
    if (act_rep.size() != 1) begin
      n_fail++; $display("FAIL midrst_count: got %0d strobes required 1", act_rep.size());
    end else begin
      n_checks++;
      if (act_rep[0].size != 16 || act_rep[0].flow != 1) begin
        n_fail++;
        $display("FAIL midrst_report: got size=%0d flow=%0d required 16 1", act_rep[0].size, act_rep[0].flow);
      end
    end
    n_checks++;
    if (err_cnt_o !== 16'd0 || act_err.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_err: got cnt=%0d pulses=%0d required 0 0", err_cnt_o, act_err.size());
    end
    clear_queues();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++)
      beat($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7), $urandom_range(0, 7));
    idle(3);
    n_checks++;
    if (act_rep.size() != exp_rep.size() || act_err.size() != exp_err.size()) begin
      n_fail++;
      $display("FAIL rand_counts: got %0d strobes %0d errors required %0d %0d",
               act_rep.size(), act_err.size(), exp_rep.size(), exp_err.size());
    end else begin
      foreach (exp_rep[i]) begin
        n_checks++;
        if (act_rep[i] != exp_rep[i]) begin
          n_fail++;
          $display("FAIL rand_report[%0d]: got cyc=%0d flow=%0d size=%0d required %0d %0d %0d", i,
                   act_rep[i].cyc, act_rep[i].flow, act_rep[i].size,
                   exp_rep[i].cyc, exp_rep[i].flow, exp_rep[i].size);
        end
      end
      foreach (exp_err[i]) begin
        n_checks++;
        if (act_err[i] != exp_err[i]) begin
          n_fail++; $display("FAIL rand_err[%0d]: got cyc %0d required %0d", i, act_err[i], exp_err[i]);
        end
      end
    end
    n_checks++;
    if (int'(err_cnt_o) != m_cnt) begin
      n_fail++; $display("FAIL rand_cnt: got %0d required %0d", err_cnt_o, m_cnt);
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_multi_beat();
    test_back_to_back();
    test_abort();
    test_idle_err();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
